dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder: the memory end of the CPU load/store port. Accepts one
//   request at a time over a valid/ready handshake, inserts programmable wait states,
//   then returns a response. Supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. Loads are
//   sign/zero extended. Misaligned, out-of-range and illegal-size requests return an error.
//   Used in place of the combinational data memory when testing CPU stall logic.
// PARAMETERS
//   DEPTH_WORDS  256   number of 32-bit words in the array; must be a power of 2
//   WAIT_CYCLES  1     extra cycles between accept and response; 0..15
//   BASE_ADDR    0     byte address of word 0; must be aligned to 4*DEPTH_WORDS
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-high reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept; req fires when req_valid && req_ready
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data; bytes are taken from the low lanes (SB [7:0], SH [15:0])
//   req_funct3  in   3   RV32I funct3 (access size and sign)
//   rsp_valid   out  1   response present
//   rsp_ready   in   1   CPU takes the response; rsp fires when rsp_valid && rsp_ready
//   rsp_rdata   out  32  load result, extended; 0 for stores and for errors
//   rsp_err     out  1   1 = request rejected (no memory side effect)
// BEHAVIOUR
//   Reset values (asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0, wait counter=0.
//   The memory array is not reset. Its contents are undefined until written.
//   FSM:
//     IDLE : req_ready=1.
//            On req fire, latch we/addr/wdata/funct3.
//            If WAIT_CYCLES==0, go to RESP; otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
//     WAIT : req_ready=0.
//            cnt decrements each cycle. When cnt==0, do the access and go to RESP.
//     RESP : req_ready=0, rsp_valid=1.
//            rsp_rdata and rsp_err are held stable until rsp fires. On rsp fire, go to IDLE.
//   Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the req fire edge.
//   Throughput: the next request can fire in the cycle after rsp fire (no combinational
//     ready path from rsp_ready).
//   Access timing: the access happens on the edge that enters RESP.
//     Stores write the array on that edge. Load data is registered into rsp_rdata on that edge.
//   Error checks, evaluated on the latched request; on error there is no write and rdata=0:
//     - offset = addr-BASE_ADDR must be < 4*DEPTH_WORDS. Unsigned compare; addr < BASE_ADDR is an error.
//     - Halfword access with addr[0]=1 is an error.
//     - Word access with addr[1:0]!=0 is an error.
//     - Loads with funct3 011/110/111 are errors.
//     - Stores with funct3 other than 000/001/010 are errors.
//   Load extension:
//     - byte lane = addr[1:0]; halfword lane = addr[1].
//     - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
//   Stores: byte-enable write of only the addressed lanes. Other bytes in the word are unchanged.
//   Word index = offset[log2(4*DEPTH_WORDS)-1:2].
//   Reset asserted in WAIT or RESP: the request is abandoned and any store not yet
//     written is discarded. Array contents already written are kept.
//   req_valid is ignored while not in IDLE. Request inputs are don't-care except on fire.
// TESTING
//   1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, err=0;
//      rsp_valid exactly WAIT_CYCLES+1 cycles after each fire.
//   2. SB wdata=0x80 @0x13:
//      LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//   3. SH @0x11 -> err=1, rdata=0; then LW @0x10 still returns 0x80ADBEEF.
//      LW @0x12 -> err=1.
//   4. Hold rsp_ready=0 for 5 cycles after a LW response ->
//      rsp_valid stays 1, rdata stable, req_ready=0, a new req_valid is not accepted.
//   5. WAIT_CYCLES=3: assert reset one cycle after an SW 0x12345678 @0x20 fires ->
//      outputs return to reset values; a later LW @0x20 returns the previous contents.
//   6. LW @BASE_ADDR+4*DEPTH_WORDS -> err=1.
//      Back-to-back LW with rsp_ready tied to 1 and WAIT_CYCLES=0 -> one response every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, with programmable wait
// states before the response. RV32I byte/half/word accesses; bad requests return an error.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned BYTE_AW  = $clog2(4 * DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lat_we_q;
  logic [31:0] lat_addr_q, lat_wdata_q;
  logic [2:0]  lat_funct3_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic                 req_fire, access, do_write;
  logic                 acc_we;
  logic [31:0]          acc_addr, acc_wdata;
  logic [2:0]           acc_funct3;
  logic [31:0]          offset, rd_word, load_val, wr_data;
  logic [BYTE_AW-3:0]   word_idx;
  logic                 range_err, align_err, funct3_err, acc_err;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [3:0]           wr_be;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_fire) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CNT_INIT;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Zero-wait accesses happen on the accept edge, so they must use the live request.
  assign acc_we     = (state_q == StIdle) ? req_we     : lat_we_q;
  assign acc_addr   = (state_q == StIdle) ? req_addr   : lat_addr_q;
  assign acc_wdata  = (state_q == StIdle) ? req_wdata  : lat_wdata_q;
  assign acc_funct3 = (state_q == StIdle) ? req_funct3 : lat_funct3_q;

  assign offset     = acc_addr - BASE_ADDR;
  assign range_err  = (offset >= SPAN);
  assign align_err  = ((acc_funct3[1:0] == 2'b01) && acc_addr[0]) ||
                      ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
  assign funct3_err = acc_we ? (acc_funct3[2] || (acc_funct3[1:0] == 2'b11))
                             : ((acc_funct3[1:0] == 2'b11) || (acc_funct3[2:1] == 2'b11));
  assign acc_err    = range_err || align_err || funct3_err;

  assign word_idx = offset[BYTE_AW-1:2];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = rd_word[{acc_addr[1:0], 3'b000} +: 8];
  assign rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = 32'h0;
    case (acc_funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone select the target.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = acc_wdata;
    case (acc_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << acc_addr[1:0];
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = acc_wdata;
      end
    endcase
  end

  assign do_write = access && acc_we && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= 32'h0;
      lat_wdata_q  <= 32'h0;
      lat_funct3_q <= 3'b000;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_fire) begin
        lat_we_q     <= req_we;
        lat_addr_q   <= req_addr;
        lat_wdata_q  <= req_wdata;
        lat_funct3_q <= req_funct3;
      end
      if (access) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'h0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 3 and 0 wait states, one with a non-zero base)
// driven by directed scenarios and random traffic checked against a byte-level memory model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [2:0]  req_funct3 [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl [3][1024];
  bit         kn  [3][1024];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS ((g == 2) ? 64 : 256),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
      .BASE_ADDR   ((g == 2) ? 32'h0000_4000 : 32'h0000_0000)
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_funct3 (req_funct3[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h0000_4000 : 32'h0000_0000;
  endfunction

  function automatic int unsigned span_of(input int d);
    return (d == 2) ? 256 : 1024;
  endfunction

  // Reference: little-endian byte array; bytes never stored are marked unknown.
  task automatic ref_access(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3,
                            output logic err, output logic [31:0] rd, output logic known);
    logic [31:0] off;
    int unsigned size;
    off   = addr - base_of(d);
    rd    = 32'h0;
    known = 1'b1;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = (size == 0) || (we && f3[2]) || (off >= span_of(d));
    if (!err) err = (addr % size) != 0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(size); i++) begin
        mdl[d][int'(off) + i] = 8'(wdata >> (8 * i));
        kn[d][int'(off) + i]  = 1'b1;
      end
    end else begin
      for (int i = 0; i < int'(size); i++) begin
        rd    = rd | (32'(mdl[d][int'(off) + i]) << (8 * i));
        known = known & kn[d][int'(off) + i];
      end
      if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8 * size));
    end
  endtask

  // Issue one request; return the response seen on its first valid cycle and the edge count
  // from the accept edge until rsp_valid shows. stable=0 if the response moved while stalled.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input int stall,
                        output logic [31:0] rd, output logic err, output int lat,
                        output logic stable);
    int n;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_funct3[d] = f3;
    rsp_ready[d]  = (stall == 0);
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[d]  = 1'b0;
    req_we[d]     = 1'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
    req_funct3[d] = 3'($urandom);
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd     = rsp_rdata[d];
    err    = rsp_err[d];
    stable = 1'b1;
    repeat (stall) begin
      @(posedge clk);
      #1;
      if (!rsp_valid[d] || rsp_rdata[d] !== rd || rsp_err[d] !== err || req_ready[d])
        stable = 1'b0;
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        failures++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", d, req_ready[d]);
      end
      checks++;
      if (rsp_valid[d] !== 1'b0) begin
        failures++; $display("FAIL reset_rsp_valid[%0d] got=%b exp=0", d, rsp_valid[d]);
      end
      checks++;
      if (rsp_rdata[d] !== 32'h0) begin
        failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", d, rsp_rdata[d]);
      end
      checks++;
      if (rsp_err[d] !== 1'b0) begin
        failures++; $display("FAIL reset_err[%0d] got=%b exp=0", d, rsp_err[d]);
      end
    end
  endtask

  task automatic test_basic();
    vec_t tbl [15];
    logic [31:0] rd;
    logic er, st;
    int lat;
    tbl = '{
      '{1'b1, 32'h10,  32'hDEADBEEF, 3'd2, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'd2, 32'hDEADBEEF,  1'b0},
      '{1'b1, 32'h13,  32'hABCDEF80, 3'd0, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h13,  32'h0,        3'd0, 32'hFFFFFF80,  1'b0},
      '{1'b0, 32'h13,  32'h0,        3'd4, 32'h0000_0080, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'd2, 32'h80ADBEEF,  1'b0},
      '{1'b1, 32'h11,  32'h0000_1234, 3'd1, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h10,  32'h0,        3'd2, 32'h80ADBEEF,  1'b0},
      '{1'b0, 32'h12,  32'h0,        3'd2, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h12,  32'h0,        3'd1, 32'hFFFF80AD,  1'b0},
      '{1'b0, 32'h12,  32'h0,        3'd5, 32'h0000_80AD, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'd3, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h10,  32'h1111_1111, 3'd4, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h10,  32'h0,        3'd2, 32'h80ADBEEF,  1'b0},
      '{1'b0, 32'h400, 32'h0,        3'd2, 32'h0000_0000, 1'b1}
    };
    for (int i = 0; i < 15; i++) begin
      do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, 0, rd, er, lat, st);
      checks++;
      if (rd !== tbl[i].exp_rd) begin
        failures++; $display("FAIL basic[%0d]_rdata got=%h exp=%h", i, rd, tbl[i].exp_rd);
      end
      checks++;
      if (er !== tbl[i].exp_err) begin
        failures++; $display("FAIL basic[%0d]_err got=%b exp=%b", i, er, tbl[i].exp_err);
      end
      checks++;
      if (lat != wait_of(0) + 1) begin
        failures++; $display("FAIL basic[%0d]_latency got=%0d exp=%0d", i, lat, wait_of(0) + 1);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] rd;
    logic er, st;
    int n, lat;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_funct3[0] = 3'd2;
    rsp_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
      req_wdata[0] = 32'hFFFF_FFFF; req_funct3[0] = 3'd2;
      checks++;
      if (rsp_valid[0] !== 1'b1) begin
        failures++; $display("FAIL hold[%0d]_rsp_valid got=%b exp=1", c, rsp_valid[0]);
      end
      checks++;
      if (rsp_rdata[0] !== 32'h80ADBEEF) begin
        failures++; $display("FAIL hold[%0d]_rdata got=%h exp=80adbeef", c, rsp_rdata[0]);
      end
      checks++;
      if (req_ready[0] !== 1'b0) begin
        failures++; $display("FAIL hold[%0d]_req_ready got=%b exp=0", c, req_ready[0]);
      end
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got valid=%b ready=%b exp valid=0 ready=1",
               rsp_valid[0], req_ready[0]);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 3'd2, 0, rd, er, lat, st);
    checks++;
    if (rd !== 32'h80ADBEEF) begin
      failures++; $display("FAIL hold_no_store got=%h exp=80adbeef", rd);
    end
  endtask

  task automatic test_reset_abandon();
    logic [31:0] rd;
    logic er, st;
    int lat;
    do_req(1, 1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 0, rd, er, lat, st);
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL abandon_sw_latency got=%0d exp=4", lat);
    end
    do_req(1, 1'b0, 32'h20, 32'h0, 3'd2, 0, rd, er, lat, st);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      failures++; $display("FAIL abandon_preload got=%h exp=cafef00d", rd);
    end
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'h12345678; req_funct3[1] = 3'd2;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    reset[1] = 1'b1;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 ||
        rsp_err[1] !== 1'b0) begin
      failures++;
      $display("FAIL abandon_reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0",
               req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
        failures++; $display("FAIL abandon_valid_in_reset got=%b exp=0", rsp_valid[1]);
      end
    end
    reset[1] = 1'b0;
    do_req(1, 1'b0, 32'h20, 32'h0, 3'd2, 0, rd, er, lat, st);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      failures++; $display("FAIL abandon_contents got=%h err=%b exp=cafef00d err=0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er, st;
    int lat, cnt;
    do_req(2, 1'b0, 32'h0000_4100, 32'h0, 3'd2, 0, rd, er, lat, st);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL b2b_top_range got err=%b rdata=%h exp err=1 rdata=0", er, rd);
    end
    checks++;
    if (lat != 1) begin
      failures++; $display("FAIL b2b_latency got=%0d exp=1", lat);
    end
    do_req(2, 1'b0, 32'h0000_3FFC, 32'h0, 3'd2, 0, rd, er, lat, st);
    checks++;
    if (er !== 1'b1) begin
      failures++; $display("FAIL b2b_below_base got err=%b exp=1", er);
    end
    do_req(2, 1'b1, 32'h0000_4040, 32'h5A5AA5A5, 3'd2, 0, rd, er, lat, st);
    checks++;
    if (er !== 1'b0) begin
      failures++; $display("FAIL b2b_store got err=%b exp=0", er);
    end
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h0000_4040; req_funct3[2] = 3'd2;
    rsp_ready[2] = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid[2]) begin
        cnt++;
        checks++;
        if (rsp_rdata[2] !== 32'h5A5AA5A5) begin
          failures++; $display("FAIL b2b_rdata got=%h exp=5a5aa5a5", rsp_rdata[2]);
        end
      end
    end
    req_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt != 10) begin
      failures++; $display("FAIL b2b_throughput got=%0d responses exp=10 in 20 cycles", cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wdata, exp_rd;
    logic er, st, we, exp_err, known;
    logic [2:0] f3;
    int lat, stall, r;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 60; k++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       addr = base_of(d) + $urandom_range(0, 63);
        else if (r == 7) addr = base_of(d) + span_of(d) - 8 + $urandom_range(0, 15);
        else if (r == 8) addr = base_of(d) - $urandom_range(1, 8);
        else             addr = $urandom;
        we    = 1'($urandom);
        f3    = 3'($urandom);
        wdata = $urandom;
        stall = $urandom_range(0, 2);
        ref_access(d, we, addr, wdata, f3, exp_err, exp_rd, known);
        do_req(d, we, addr, wdata, f3, stall, rd, er, lat, st);
        checks++;
        if (er !== exp_err) begin
          failures++;
          $display("FAIL rnd[%0d.%0d]_err we=%b addr=%h f3=%0d got=%b exp=%b",
                   d, k, we, addr, f3, er, exp_err);
        end
        if (known) begin
          checks++;
          if (rd !== exp_rd) begin
            failures++;
            $display("FAIL rnd[%0d.%0d]_rdata we=%b addr=%h f3=%0d got=%h exp=%h",
                     d, k, we, addr, f3, rd, exp_rd);
          end
        end
        checks++;
        if (lat != wait_of(d) + 1) begin
          failures++;
          $display("FAIL rnd[%0d.%0d]_latency got=%0d exp=%0d", d, k, lat, wait_of(d) + 1);
        end
        checks++;
        if (st !== 1'b1) begin
          failures++; $display("FAIL rnd[%0d.%0d]_stall_stable got=%b exp=1", d, k, st);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset[d]      = 1'b1;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_addr[d]   = 32'h0;
      req_wdata[d]  = 32'h0;
      req_funct3[d] = 3'd0;
      rsp_ready[d]  = 1'b1;
      for (int i = 0; i < 1024; i++) begin
        mdl[d][i] = 8'h0;
        kn[d][i]  = 1'b0;
      end
    end
    #12;
    test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    test_basic();
    test_hold();
    test_reset_abandon();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
